// File: rtl/srrc_pkg.sv
// Shared SRRC constants used by both transmitter and receiver: Q-formats,
// the 33-tap coefficient table, receiver FSM states and symbol codes.
package srrc_pkg;

    localparam int unsigned TAPS     = 33;
    localparam int unsigned DATA_W   = 18;
    localparam int unsigned COEF_W   = 16;
    localparam int unsigned ACC_W    = 40;
    localparam int unsigned FRAC_W   = 14;
    localparam int unsigned PROD_W   = DATA_W + COEF_W;
    localparam int unsigned PH_W     = 3;
    localparam int unsigned FILL_W   = 5;
    localparam int unsigned FILL_LEN = 32;

    // Symmetric Q2.14 taps: c17..c32 mirror c15..c0
    localparam logic signed [COEF_W-1:0] COEFS [TAPS] = '{
        -16'sd168,  -16'sd54,    16'sd185,   16'sd267,   16'sd36,
        -16'sd276,  -16'sd233,   16'sd278,   16'sd709,   16'sd238,
        -16'sd1262, -16'sd2592, -16'sd1730,  16'sd2598,  16'sd9499,
         16'sd15958, 16'sd18600, 16'sd15958, 16'sd9499,  16'sd2598,
        -16'sd1730, -16'sd2592, -16'sd1262,  16'sd238,   16'sd709,
         16'sd278,  -16'sd233,  -16'sd276,   16'sd36,    16'sd267,
         16'sd185,  -16'sd54,   -16'sd168
    };

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (FRAC_W - 1));
    localparam logic signed [ACC_W-1:0] MF_MAX   = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] MF_MIN   = -ACC_W'(2 ** (DATA_W - 1));

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } rx_state_t;

    localparam logic [1:0] SYM_POS = 2'b01;
    localparam logic [1:0] SYM_NEG = 2'b11;

endpackage

// File: rtl/srrc_rx_slicer.sv
// Symbol timing and decision: warm-up FSM, phase counter and the registered
// sign slicer that turns a matched-filter sample into a 2-bit symbol.
module srrc_rx_slicer
    import srrc_pkg::*;
#(
    parameter int unsigned OSR          = 4,
    parameter int unsigned SAMPLE_PHASE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din_valid,
    input  logic       mf_neg,
    output logic [1:0] Dout,
    output logic       dout_valid
);

    rx_state_t         state;
    rx_state_t         state_next;
    logic [FILL_W-1:0] fill_cnt;
    logic [PH_W-1:0]   phase;
    logic              take;
    logic              take_d1;
    logic              take_d2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (din_valid) state_next = FILL;
            FILL:    if (din_valid && fill_cnt == FILL_W'(FILL_LEN - 1)) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        take = din_valid && (state == RUN) && (phase == PH_W'(SAMPLE_PHASE));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_cnt <= '0;
            phase    <= '0;
        end else if (din_valid) begin
            if (state != RUN) begin
                fill_cnt <= fill_cnt + 1'b1;
            end else begin
                phase <= (phase == PH_W'(OSR - 1)) ? '0 : phase + 1'b1;
            end
        end
    end

    // The filter output for a sample lands one edge after acceptance, so the
    // decision flag is carried two stages to meet the registered mf_out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            take_d1    <= 1'b0;
            take_d2    <= 1'b0;
            Dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            take_d1    <= take;
            take_d2    <= take_d1;
            dout_valid <= take_d2;
            if (take_d2) begin
                Dout <= mf_neg ? SYM_NEG : SYM_POS;
            end
        end
    end

endmodule

// File: rtl/srrc_rx.sv
// SRRC receiver: 33-tap matched filter, warm-up and symbol decision.
// Define SRRC_RX_SAT_EN to clamp mf_out and expose the sticky sat flag.
module srrc_rx
    import srrc_pkg::*;
#(
    parameter int unsigned OSR          = 4,
    parameter int unsigned SAMPLE_PHASE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     din_valid,
    input  logic signed [DATA_W-1:0] Din,
    output logic                     mf_valid,
    output logic signed [DATA_W-1:0] mf_out,
    output logic [1:0]               Dout,
    output logic                     dout_valid
`ifdef SRRC_RX_SAT_EN
    ,
    output logic                     sat
`endif
);

    logic signed [DATA_W-1:0] dl [TAPS];
    logic                     vld_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] mf_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                dl[k] <= '0;
            end
            vld_d <= 1'b0;
        end else begin
            vld_d <= din_valid;
            if (din_valid) begin
                dl[0] <= Din;
                for (int unsigned k = 1; k < TAPS; k++) begin
                    dl[k] <= dl[k-1];
                end
            end
        end
    end

    always_comb begin
        acc  = '0;
        prod = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            prod = PROD_W'(dl[k]) * PROD_W'(COEFS[k]);
            acc  = acc + ACC_W'(prod);
        end
    end

`ifdef SRRC_RX_SAT_EN
    logic signed [ACC_W-1:0] rnd;
    logic                    clamp;

    always_comb begin
        rnd   = (acc + RND_HALF) >>> FRAC_W;
        clamp = (rnd > MF_MAX) || (rnd < MF_MIN);
        if (rnd > MF_MAX) begin
            mf_next = DATA_W'(MF_MAX);
        end else if (rnd < MF_MIN) begin
            mf_next = DATA_W'(MF_MIN);
        end else begin
            mf_next = DATA_W'(rnd);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sat <= 1'b0;
        end else if (vld_d && clamp) begin
            sat <= 1'b1;
        end
    end
`else
    always_comb begin
        mf_next = DATA_W'((acc + RND_HALF) >>> FRAC_W);
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            mf_valid <= 1'b0;
            mf_out   <= '0;
        end else begin
            mf_valid <= vld_d;
            if (vld_d) begin
                mf_out <= mf_next;
            end
        end
    end

    srrc_rx_slicer #(
        .OSR          (OSR),
        .SAMPLE_PHASE (SAMPLE_PHASE)
    ) u_slicer (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .mf_neg     (mf_out[DATA_W-1]),
        .Dout       (Dout),
        .dout_valid (dout_valid)
    );

endmodule

// File: tb/tb_srrc_rx.sv
// Scoreboard bench for srrc_rx: directed sample streams push expected
// filter outputs and decisions; a negedge monitor pops and compares them.
module tb_srrc_rx;
    import srrc_pkg::*;

    localparam int OSR_T = 4;
    localparam int PH_T  = 0;

    localparam int C_TAB [33] = '{
        -168, -54, 185, 267, 36, -276, -233, 278, 709, 238, -1262, -2592,
        -1730, 2598, 9499, 15958, 18600, 15958, 9499, 2598, -1730, -2592,
        -1262, 238, 709, 278, -233, -276, 36, 267, 185, -54, -168
    };

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               din_valid = 1'b0;
    logic signed [17:0] Din = '0;
    logic               mf_valid;
    logic signed [17:0] mf_out;
    logic [1:0]         Dout;
    logic               dout_valid;
`ifdef SRRC_RX_SAT_EN
    logic               sat;
`endif

    srrc_rx #(
        .OSR          (OSR_T),
        .SAMPLE_PHASE (PH_T)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .Din        (Din),
        .mf_valid   (mf_valid),
        .mf_out     (mf_out),
        .Dout       (Dout),
        .dout_valid (dout_valid)
`ifdef SRRC_RX_SAT_EN
        ,
        .sat        (sat)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          val;
        int unsigned due;
        bit          sat;
    } mf_item_t;

    typedef struct {
        logic [1:0]  code;
        int unsigned due;
    } dv_item_t;

    mf_item_t mf_q[$];
    dv_item_t dv_q[$];
    int       hist [33];
    int       idx = 0;
    bit       sat_model = 1'b0;
    int       checks = 0;
    int       errors = 0;
    mf_item_t m_it;
    dv_item_t d_it;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected filter output for the current bench history (round, then clamp or wrap)
    function automatic int model_mf(output bit clamped);
        longint             acc;
        longint             r;
        logic signed [17:0] w;
        acc = 0;
        clamped = 1'b0;
        for (int k = 0; k < 33; k++) acc += longint'(C_TAB[k]) * longint'(hist[k]);
        r = (acc + 8192) >>> 14;
`ifdef SRRC_RX_SAT_EN
        if (r > 131071) begin
            r = 131071;
            clamped = 1'b1;
        end else if (r < -131072) begin
            r = -131072;
            clamped = 1'b1;
        end
        return int'(r);
`else
        w = r[17:0];
        return int'(w);
`endif
    endfunction

    task automatic send(input bit v, input int val);
        int       e;
        bit       cl;
        mf_item_t mi;
        dv_item_t di;
        @(negedge clk);
        reset     = 1'b1;
        din_valid = v;
        Din       = 18'(val);
        if (v) begin
            for (int k = 32; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = val;
            e = model_mf(cl);
            if (cl) sat_model = 1'b1;
            mi.val = e;
            mi.due = cyc + 2;
            mi.sat = sat_model;
            mf_q.push_back(mi);
            if (idx >= 32 && ((idx - 32) % OSR_T) == PH_T) begin
                di.code = (e < 0) ? 2'b11 : 2'b01;
                di.due  = cyc + 3;
                dv_q.push_back(di);
            end
            idx++;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset     = 1'b0;
        din_valid = 1'b1;
        Din       = 18'sd1000;
        // Anything due at or after the reset edge is aborted
        while (mf_q.size() > 0 && mf_q[$].due > cyc) void'(mf_q.pop_back());
        while (dv_q.size() > 0 && dv_q[$].due > cyc) void'(dv_q.pop_back());
        for (int k = 0; k < 33; k++) hist[k] = 0;
        idx       = 0;
        sat_model = 1'b0;
        repeat (n) @(negedge clk);
        reset     = 1'b1;
        din_valid = 1'b0;
        Din       = '0;
        chk("rst mf_valid", longint'(mf_valid), 0);
        chk("rst mf_out", longint'(mf_out), 0);
        chk("rst Dout", longint'(Dout), 0);
        chk("rst dout_valid", longint'(dout_valid), 0);
        chk("rst state", longint'(int'(u_dut.u_slicer.state)), longint'(int'(IDLE)));
`ifdef SRRC_RX_SAT_EN
        chk("rst sat", longint'(sat), 0);
`endif
    endtask

    always @(negedge clk) begin
        if (mf_valid === 1'b1) begin
            if (mf_q.size() == 0) begin
                chk("mf_valid unexpected", 1, 0);
            end else begin
                m_it = mf_q.pop_front();
                chk("mf_out", longint'(mf_out), longint'(m_it.val));
                chk("mf timing", longint'(cyc), longint'(m_it.due));
`ifdef SRRC_RX_SAT_EN
                chk("sat", longint'(sat), longint'(m_it.sat));
`endif
            end
        end
        if (dout_valid === 1'b1) begin
            if (dv_q.size() == 0) begin
                chk("dout_valid unexpected", 1, 0);
            end else begin
                d_it = dv_q.pop_front();
                chk("Dout", longint'(Dout), longint'(d_it.code));
                chk("dout timing", longint'(cyc), longint'(d_it.due));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 33; k++) hist[k] = 0;
        do_reset(3);

        // Impulse: outputs walk the tap table, decisions at 32 (c32<0), 36, 40 (zero)
        send(1'b1, 16384);
        repeat (42) send(1'b1, 0);
        repeat (4) send(1'b0, 0);

        // Constant -1.0: negative decisions every OSR samples once warm
        do_reset(1);
        repeat (44) send(1'b1, -16384);
        repeat (4) send(1'b0, 0);

        // Same stream with stalls, including some longer gaps
        do_reset(1);
        for (int i = 0; i < 44; i++) begin
            send(1'b1, -16384);
            repeat ((i % 8 == 7) ? 3 : 1) send(1'b0, 0);
        end
        repeat (4) send(1'b0, 0);

        // Reset right after sample 40 aborts its results; warm-up repeats
        do_reset(1);
        repeat (41) send(1'b1, 16384);
        do_reset(1);
        repeat (34) send(1'b1, 16384);
        repeat (4) send(1'b0, 0);

        // Large input: clamps (and sets sat) or wraps depending on build
        do_reset(1);
        repeat (36) send(1'b1, 131071);
        repeat (8) send(1'b1, 0);
        repeat (4) send(1'b0, 0);
`ifdef SRRC_RX_SAT_EN
        chk("sat sticky", longint'(sat), 1);
`endif

        chk("mf queue drained", longint'(mf_q.size()), 0);
        chk("dout queue drained", longint'(dv_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
